// File: rtl/dm_wait_responder.sv
// Data-memory responder with programmable wait states.
// Byte-enabled word writes; reads right-aligned with sign/zero extension.
module dm_wait_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [3:0]        req_be,
    input  logic [31:0]       req_wdata,
    input  logic              req_signed,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam int         DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [31:0]         rsp_rdata_q;

    logic                we_q;
    logic                signed_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [3:0]          be_q;
    logic [31:0]         wdata_q;

    logic [31:0]         mem_q [DEPTH];

    logic [31:0]         word;
    logic [31:0]         rdata_d;
    logic                fire_d;
    logic                commit_d;

    assign word     = mem_q[addr_q];
    assign fire_d   = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign commit_d = rst && fire_d && we_q;

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

    // Lane extraction and extension of the addressed word for reads
    always_comb begin
        rdata_d = 32'd0;
        case (be_q)
            4'b1111: rdata_d = word;
            4'b0011: rdata_d = {{16{signed_q & word[15]}}, word[15:0]};
            4'b1100: rdata_d = {{16{signed_q & word[31]}}, word[31:16]};
            4'b0001: rdata_d = {{24{signed_q & word[7]}}, word[7:0]};
            4'b0010: rdata_d = {{24{signed_q & word[15]}}, word[15:8]};
            4'b0100: rdata_d = {{24{signed_q & word[23]}}, word[23:16]};
            4'b1000: rdata_d = {{24{signed_q & word[31]}}, word[31:24]};
            default: rdata_d = word & {{8{be_q[3]}}, {8{be_q[2]}},
                                       {8{be_q[1]}}, {8{be_q[0]}}};
        endcase
    end

    // Array write port: enabled lanes only, never touched by reset
    always_ff @(posedge clk) begin
        if (commit_d) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem_q[addr_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Handshake FSM with wait counter and registered outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            we_q        <= 1'b0;
            signed_q    <= 1'b0;
            addr_q      <= '0;
            be_q        <= 4'd0;
            wdata_q     <= 32'd0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (req_valid && req_ready_q) begin
                        state_q     <= S_WAIT;
                        cnt_q       <= LAT;
                        req_ready_q <= 1'b0;
                        we_q        <= req_we;
                        signed_q    <= req_signed;
                        addr_q      <= req_addr;
                        be_q        <= req_be;
                        wdata_q     <= req_wdata;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= we_q ? 32'd0 : rdata_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dm_wait_responder.sv
// Directed bench for dm_wait_responder.
// Two instances: default build, and LATENCY=0 with a small array for wrap.
module tb_dm_wait_responder;

    logic        clk = 1'b0;
    logic        rst;
    int          errors = 0;
    int          checks = 0;

    logic        req_valid, req_ready, req_we, req_signed;
    logic [9:0]  req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;

    logic        req_valid_b, req_ready_b, req_we_b, req_signed_b;
    logic [3:0]  req_addr_b;
    logic [3:0]  req_be_b;
    logic [31:0] req_wdata_b;
    logic        rsp_valid_b;
    logic        rsp_ready_b = 1'b1;
    logic [31:0] rsp_rdata_b;

    always #5 clk = ~clk;

    dm_wait_responder #(.ADDR_W(10), .LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_be(req_be),
        .req_wdata(req_wdata), .req_signed(req_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata)
    );

    dm_wait_responder #(.ADDR_W(4), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we_b), .req_addr(req_addr_b), .req_be(req_be_b),
        .req_wdata(req_wdata_b), .req_signed(req_signed_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b),
        .rsp_rdata(rsp_rdata_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // One transaction on the LATENCY=2 instance; hold = cycles of backpressure
    task automatic xa(input logic we, input logic [9:0] a,
                      input logic [3:0] be, input logic [31:0] wd,
                      input logic sg, input logic [31:0] exp,
                      input int hold, input string tag);
        int k;
        logic [31:0] first;
        chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = a;
        req_be = be; req_wdata = wd; req_signed = sg;
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_addr = ~a;
        req_be = ~be; req_wdata = ~wd; req_signed = ~sg;
        k = 0;
        while (!rsp_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, "_lat"}, 32'(k), 32'd3);
        chk({tag, "_data"}, rsp_rdata, exp);
        first = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_v"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_hold_d"}, rsp_rdata, first);
            chk({tag, "_hold_r"}, 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({tag, "_vdrop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rdy2"}, 32'(req_ready), 32'd1);
    endtask

    // One full-word transaction on the LATENCY=0 instance
    task automatic xb(input logic we, input logic [3:0] a,
                      input logic [31:0] wd, input logic [31:0] exp,
                      input string tag);
        chk({tag, "_rdy"}, 32'(req_ready_b), 32'd1);
        req_valid_b = 1'b1; req_we_b = we; req_addr_b = a;
        req_be_b = 4'hF; req_wdata_b = wd; req_signed_b = 1'b0;
        @(negedge clk);
        req_valid_b = 1'b0; req_wdata_b = ~wd; req_addr_b = ~a;
        chk({tag, "_wait"}, 32'(rsp_valid_b), 32'd0);
        @(negedge clk);
        chk({tag, "_v"}, 32'(rsp_valid_b), 32'd1);
        chk({tag, "_data"}, rsp_rdata_b, exp);
        @(negedge clk);
        chk({tag, "_vdrop"}, 32'(rsp_valid_b), 32'd0);
        chk({tag, "_rdy2"}, 32'(req_ready_b), 32'd1);
    endtask

    initial begin
        rst = 1'b0; rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd5;
        req_be = 4'hF; req_wdata = 32'h11111111; req_signed = 1'b0;
        req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = 4'd0;
        req_be_b = 4'hF; req_wdata_b = 32'd0; req_signed_b = 1'b0;

        // reset held with a pending request
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_rdy", 32'(req_ready), 32'd0);
            chk("rst_vld", 32'(rsp_valid), 32'd0);
            chk("rst_data", rsp_rdata, 32'd0);
        end
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rel_rdy", 32'(req_ready), 32'd1);

        // word write then read
        xa(1'b1, 10'd5, 4'hF, 32'hDEADBEEF, 1'b0, 32'd0, 0, "t2_wr");
        xa(1'b0, 10'd5, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 0, "t2_rd");

        // byte write and extended reads
        xa(1'b1, 10'd5, 4'b0010, 32'h0000AA00, 1'b0, 32'd0, 0, "t3_wr");
        xa(1'b0, 10'd5, 4'hF, 32'h0, 1'b0, 32'hDEADAAEF, 0, "t3_w");
        xa(1'b0, 10'd5, 4'b0010, 32'h0, 1'b1, 32'hFFFFFFAA, 0, "t3_b1s");
        xa(1'b0, 10'd5, 4'b0010, 32'h0, 1'b0, 32'h000000AA, 0, "t3_b1u");
        xa(1'b0, 10'd5, 4'b1100, 32'h0, 1'b1, 32'hFFFFDEAD, 0, "t3_h1s");
        xa(1'b0, 10'd5, 4'b0011, 32'h0, 1'b1, 32'hFFFFAAEF, 0, "t3_h0s");
        xa(1'b0, 10'd5, 4'b0001, 32'h0, 1'b1, 32'hFFFFFFEF, 0, "t3_b0s");
        xa(1'b0, 10'd5, 4'b1000, 32'h0, 1'b0, 32'h000000DE, 0, "t3_b3u");
        xa(1'b0, 10'd5, 4'b0101, 32'h0, 1'b1, 32'h00AD00EF, 0, "t3_mix");
        xa(1'b1, 10'd5, 4'b0000, 32'h01234567, 1'b0, 32'd0, 0, "t3_be0");
        xa(1'b0, 10'd5, 4'hF, 32'h0, 1'b0, 32'hDEADAAEF, 0, "t3_be0rd");

        // backpressure in RESP
        xa(1'b0, 10'd5, 4'hF, 32'h0, 1'b0, 32'hDEADAAEF, 5, "t4_bp");

        // reset while a write waits
        xa(1'b1, 10'd9, 4'hF, 32'hCAFEF00D, 1'b0, 32'd0, 0, "t5_pre");
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd9;
        req_be = 4'hF; req_wdata = 32'h12345678;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_vld", 32'(rsp_valid), 32'd0);
        chk("t5_rst_rdy", 32'(req_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        xa(1'b0, 10'd9, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D, 0, "t5_rd");

        // reset with a write request presented must not write
        xa(1'b1, 10'd7, 4'hF, 32'h5A5A5A5A, 1'b0, 32'd0, 0, "t1_pre");
        rst = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'd7;
        req_be = 4'hF; req_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t1_rdy", 32'(req_ready), 32'd0);
            chk("t1_vld", 32'(rsp_valid), 32'd0);
        end
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        xa(1'b0, 10'd7, 4'hF, 32'h0, 1'b0, 32'h5A5A5A5A, 0, "t1_rd");

        // LATENCY=0, address wrap, back-to-back
        xb(1'b1, 4'd15, 32'h0BADF00D, 32'd0, "t6_w15");
        xb(1'b1, 4'd0, 32'h76543210, 32'd0, "t6_w0");
        xb(1'b0, 4'd15, 32'h0, 32'h0BADF00D, "t6_r15");
        xb(1'b0, 4'd0, 32'h0, 32'h76543210, "t6_r0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
